cnn_bias_relu_new: RTL and testbench
====================================

CNN_BIAS_RELU_NEW -- requirements
Module: cnn_bias_relu_new

Interface
REQ-001: DATA_WIDTH, 16, signed two's-complement fixed-point width of pixels and biases.
REQ-002: IMAGE_SIZE, 93636, pixels per output channel per frame.
REQ-003: CHANNEL_NUM_OUT, 256, output channels per frame and bias entries.
REQ-004: clk  input  1  single clock; all logic on rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: valid_in  input  1  pxl_in valid this cycle; no backpressure.
REQ-007: pxl_in  input  DATA_WIDTH  summed conv pixel, channel-major order (all IMAGE_SIZE pixels of ch0, then ch1, ...).
REQ-008: valid_bias_in  input  1  bias_in valid this cycle.
REQ-009: bias_in  input  DATA_WIDTH  bias for the next channel index, loaded ch0 first.
REQ-010: pxl_out  output  DATA_WIDTH  biased, saturated, optionally rectified pixel.
REQ-011: valid_out  output  1  pxl_out valid.
REQ-012: bias_loaded  output  1  high while all CHANNEL_NUM_OUT biases are held.
REQ-013: frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame.
REQ-014: err_drop  output  1  sticky: a pixel was discarded.

Function
REQ-015: FSM states LOAD and RUN; LOAD after reset.
REQ-016: LOAD: each valid_bias_in writes bias_in at bias index, index increments; after write of index CHANNEL_NUM_OUT-1, next state RUN, bias_loaded=1.
REQ-017: RUN: each valid_in consumes one pixel; pixel counter 0..IMAGE_SIZE-1, channel counter 0..CHANNEL_NUM_OUT-1; pixel wrap increments channel; channel wrap returns to 0 (next frame, same biases).
REQ-018: Stage 1 register: sum = sext(pxl_in) + sext(bias[channel]) at DATA_WIDTH+1 bits.
REQ-019: Stage 2 register: saturate sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then ReLU per REQ-027.
REQ-020: Latency exactly 2 cycles valid_in->valid_out; throughput one pixel/cycle, back-to-back.
REQ-021: valid_in in LOAD: pixel dropped, err_drop set, no output.
REQ-022: valid_bias_in in RUN: abort frame, go to LOAD, write bias_in to index 0 (next index 1), clear pixel/channel counters, bias_loaded=0; in-flight pipeline pixels still emitted.
REQ-023: valid_in and valid_bias_in same cycle: bias wins per REQ-016/REQ-022; pixel dropped, err_drop set.
REQ-024: frame_done asserted with output of pixel IMAGE_SIZE-1 of channel CHANNEL_NUM_OUT-1.
REQ-025: pxl_out holds last value when valid_out=0.

Reset
REQ-026: Reset asserted: state LOAD, counters 0, bias index 0, pipeline valids 0, pxl_out 0, valid_out 0, bias_loaded 0, frame_done 0, err_drop 0; bias storage contents need not clear; mid-frame reset discards in-flight pixels.

Configuration
REQ-027: CNN_BIAS_RELU_EN defined: negative saturated results output as 0; undefined: saturated result passed unchanged; latency identical either way.

Structure
REQ-028: Shared package cnn_bias_pkg holds DATA_WIDTH-derived saturation constants and clog2-based counter widths for IMAGE_SIZE and CHANNEL_NUM_OUT.
REQ-029: Bias storage in sub-module cnn_bias_ram (single write port, combinational read by channel counter); FSM, counters and pipeline in top.

Verification
REQ-030: Load biases 0..255 = +10, stream 1 frame IMAGE_SIZE=4 of pxl_in=5 -> all pxl_out=15, 2-cycle latency, one frame_done on final pixel.
REQ-031: bias=-20, pxl_in=5 -> pxl_out=0 with CNN_BIAS_RELU_EN, 0xFFF1 (-15) without.
REQ-032: bias=0x7FFF, pxl_in=0x0001 -> pxl_out=0x7FFF; bias=0x8000, pxl_in=0xFFFF, macro off -> 0x8000.
REQ-033: valid_in during LOAD, and valid_in with valid_bias_in in RUN -> no output for those pixels, err_drop=1 and stays 1, state LOAD after the collision.
REQ-034: Assert reset mid-frame after 3 pixels -> all outputs 0 next cycle, bias_loaded=0, no valid_out until biases reloaded and new pixels sent.

Source files
------------

// File: rtl/cnn_bias_relu_new_pkg.sv
// Shared constants for the bias + ReLU stage: default sizes, counter widths, saturation limits.
// The CNN_BIAS_RELU_EN macro is consumed by the top; this package is macro-independent.
package cnn_bias_pkg;

  localparam int DATA_WIDTH          = 16;
  localparam int DEF_IMAGE_SIZE      = 93636;
  localparam int DEF_CHANNEL_NUM_OUT = 256;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  // Counters need at least one bit even for a degenerate size of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PIX_CNT_W = cnt_w(DEF_IMAGE_SIZE);
  localparam int CH_CNT_W  = cnt_w(DEF_CHANNEL_NUM_OUT);

  // Overflow of the widened sum shows up as disagreement of its top two bits.
  function automatic logic [DATA_WIDTH-1:0] sat_relu(input logic [DATA_WIDTH:0] s,
                                                     input logic relu_en);
    logic [DATA_WIDTH-1:0] r;
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      r = s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    else
      r = s[DATA_WIDTH-1:0];
    if (relu_en && r[DATA_WIDTH-1])
      r = '0;
    return r;
  endfunction

endpackage

// File: rtl/cnn_bias_relu_new_if.sv
// Pixel/bias stream interface of cnn_bias_relu_new; master drives pixels and biases.
interface cnn_bias_relu_new_if
  import cnn_bias_pkg::*;
#(
  parameter int DW = DATA_WIDTH
);
  logic          valid_in;
  logic [DW-1:0] pxl_in;
  logic          valid_bias_in;
  logic [DW-1:0] bias_in;
  logic [DW-1:0] pxl_out;
  logic          valid_out;
  logic          bias_loaded;
  logic          frame_done;
  logic          err_drop;

  modport master (
    output valid_in, pxl_in, valid_bias_in, bias_in,
    input  pxl_out, valid_out, bias_loaded, frame_done, err_drop
  );

  modport slave (
    input  valid_in, pxl_in, valid_bias_in, bias_in,
    output pxl_out, valid_out, bias_loaded, frame_done, err_drop
  );
endinterface

// File: rtl/cnn_bias_relu_new_ram.sv
// Per-channel bias storage: one synchronous write port, combinational read.
module cnn_bias_ram
  import cnn_bias_pkg::*;
#(
  parameter int DEPTH  = DEF_CHANNEL_NUM_OUT,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cnn_bias_relu_new.sv
// Bias add + saturate (+ optional ReLU when CNN_BIAS_RELU_EN is defined), 2-cycle pipeline.
// FSM LOAD collects one bias per output channel; RUN streams channel-major pixels.
module cnn_bias_relu_new
  import cnn_bias_pkg::*;
#(
  parameter int IMAGE_SIZE      = DEF_IMAGE_SIZE,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT
) (
  input logic               clk,
  input logic               reset,
  cnn_bias_relu_new_if.slave bus
);
  localparam int PIX_W = cnt_w(IMAGE_SIZE);
  localparam int CH_W  = cnt_w(CHANNEL_NUM_OUT);

`ifdef CNN_BIAS_RELU_EN
  localparam logic RELU_EN = 1'b1;
`else
  localparam logic RELU_EN = 1'b0;
`endif

  state_t                r_state;
  logic [PIX_W-1:0]      r_pix_cnt;
  logic [CH_W-1:0]       r_ch_cnt;
  logic [CH_W-1:0]       r_bias_idx;
  logic                  r_bias_loaded;
  logic                  r_err_drop;
  logic                  r_s1_vld;
  logic                  r_s1_last;
  logic [DATA_WIDTH:0]   r_s1_sum;
  logic                  r_valid_out;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_pxl_out;

  logic                  w_accept;
  logic                  w_pix_wrap;
  logic                  w_ch_wrap;
  logic [CH_W-1:0]       w_waddr;
  logic [DATA_WIDTH-1:0] w_bias;

  // A bias write always takes priority over a pixel in the same cycle.
  assign w_accept   = bus.valid_in && !bus.valid_bias_in && (r_state == ST_RUN);
  assign w_pix_wrap = (r_pix_cnt == PIX_W'(IMAGE_SIZE - 1));
  assign w_ch_wrap  = (r_ch_cnt == CH_W'(CHANNEL_NUM_OUT - 1));
  assign w_waddr    = (r_state == ST_RUN) ? '0 : r_bias_idx;

  cnn_bias_ram #(
    .DEPTH  (CHANNEL_NUM_OUT),
    .ADDR_W (CH_W)
  ) u_bias_ram (
    .clk     (clk),
    .i_we    (bus.valid_bias_in),
    .i_waddr (w_waddr),
    .i_wdata (bus.bias_in),
    .i_raddr (r_ch_cnt),
    .o_rdata (w_bias)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_LOAD;
      r_pix_cnt     <= '0;
      r_ch_cnt      <= '0;
      r_bias_idx    <= '0;
      r_bias_loaded <= 1'b0;
      r_err_drop    <= 1'b0;
      r_s1_vld      <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_sum      <= '0;
      r_valid_out   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_pxl_out     <= '0;
    end else begin
      if (bus.valid_in && (bus.valid_bias_in || r_state == ST_LOAD))
        r_err_drop <= 1'b1;

      if (bus.valid_bias_in) begin
        case (r_state)
          ST_LOAD: begin
            if (r_bias_idx == CH_W'(CHANNEL_NUM_OUT - 1)) begin
              r_bias_idx    <= '0;
              r_bias_loaded <= 1'b1;
              r_state       <= ST_RUN;
            end else begin
              r_bias_idx <= r_bias_idx + CH_W'(1);
            end
          end
          default: begin
            // Abort: this bias already lands at index 0, so the reload continues at 1.
            r_bias_idx    <= CH_W'(1);
            r_bias_loaded <= 1'b0;
            r_pix_cnt     <= '0;
            r_ch_cnt      <= '0;
            r_state       <= ST_LOAD;
          end
        endcase
      end else if (w_accept) begin
        r_pix_cnt <= w_pix_wrap ? '0 : r_pix_cnt + PIX_W'(1);
        if (w_pix_wrap)
          r_ch_cnt <= w_ch_wrap ? '0 : r_ch_cnt + CH_W'(1);
      end

      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_sum  <= {bus.pxl_in[DATA_WIDTH-1], bus.pxl_in} + {w_bias[DATA_WIDTH-1], w_bias};
        r_s1_last <= w_pix_wrap && w_ch_wrap;
      end

      r_valid_out  <= r_s1_vld;
      r_frame_done <= r_s1_vld && r_s1_last;
      if (r_s1_vld)
        r_pxl_out <= sat_relu(r_s1_sum, RELU_EN);
    end
  end

  assign bus.pxl_out     = r_pxl_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.bias_loaded = r_bias_loaded;
  assign bus.frame_done  = r_frame_done;
  assign bus.err_drop    = r_err_drop;
endmodule

// File: tb/tb_cnn_bias_relu_new.sv
// Bench for cnn_bias_relu_new with IMAGE_SIZE=4; expected pixels queued at drive time.
// Honours CNN_BIAS_RELU_EN the same way the design does.
module tb_cnn_bias_relu_new;
  import cnn_bias_pkg::*;

  localparam int IMG = 4;
  localparam int CH  = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cnn_bias_relu_new_if #(.DW(DATA_WIDTH)) bus ();

  cnn_bias_relu_new #(
    .IMAGE_SIZE      (IMG),
    .CHANNEL_NUM_OUT (CH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic        last;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   n_frame = 0;

  // reference model of the control path
  bit                 m_run;
  int                 m_idx, m_pix, m_ch;
  logic signed [15:0] m_bias [CH];

  function automatic logic [15:0] ref_out(input int p, input int b);
    int s;
    s = p + b;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef CNN_BIAS_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic step(input bit vb, input logic [15:0] b, input bit vp, input logic [15:0] p);
    @(posedge clk);
    #1;
    bus.valid_bias_in = vb;
    bus.bias_in       = b;
    bus.valid_in      = vp;
    bus.pxl_in        = p;
    if (vb) begin
      if (!m_run) begin
        m_bias[m_idx] = b;
        if (m_idx == CH - 1) begin m_run = 1; m_idx = 0; end
        else m_idx++;
      end else begin
        m_bias[0] = b;
        m_idx = 1; m_run = 0; m_pix = 0; m_ch = 0;
      end
    end else if (vp && m_run) begin
      sbq.push_back('{ref_out(int'($signed(p)), int'(m_bias[m_ch])),
                      (m_pix == IMG - 1) && (m_ch == CH - 1), cyc + 2});
      if (m_pix == IMG - 1) begin
        m_pix = 0;
        m_ch  = (m_ch == CH - 1) ? 0 : m_ch + 1;
      end else m_pix++;
    end
  endtask

  task automatic idle();
    step(0, 16'h0, 0, 16'h0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (bus.valid_out) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got=%h req=no_output cyc=%0d", bus.pxl_out, cyc);
        end else begin
          mon_e = sbq.pop_front();
          if (bus.pxl_out !== mon_e.d || bus.frame_done !== mon_e.last || cyc !== mon_e.due) begin
            errors++;
            $display("FAIL pixel_out got=%h/fd%b@%0d req=%h/fd%b@%0d",
                     bus.pxl_out, bus.frame_done, cyc, mon_e.d, mon_e.last, mon_e.due);
          end
        end
        if (bus.frame_done) n_frame++;
      end else if (bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_idle got=%b req=0", bus.frame_done);
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        errors++;
        $display("FAIL missing_out got=no_output req=%h due=%0d", sbq[0].d, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.valid_in = 0; bus.valid_bias_in = 0; bus.pxl_in = '0; bus.bias_in = '0;
    sbq.delete();
    m_run = 0; m_idx = 0; m_pix = 0; m_ch = 0;
    #2;
    checks++;
    if (bus.pxl_out !== 16'h0 || bus.valid_out !== 1'b0 || bus.bias_loaded !== 1'b0 ||
        bus.frame_done !== 1'b0 || bus.err_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b/%b req=0000/0/0/0/0", bus.pxl_out,
               bus.valid_out, bus.bias_loaded, bus.frame_done, bus.err_drop);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_biases(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] rest);
    for (int i = m_idx; i < CH; i++)
      step(1, (i == 0) ? b0 : (i == 1) ? b1 : rest, 0, 16'h0);
    idle();
    checks++;
    if (bus.bias_loaded !== 1'b1) begin
      errors++;
      $display("FAIL bias_loaded got=%b req=1", bus.bias_loaded);
    end
  endtask

  task automatic stream(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) step(0, 16'h0, 1, p);
    idle();
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_pending req=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_frame();
    do_reset();
    n_frame = 0;
    load_biases(16'd10, 16'd10, 16'd10);
    stream(IMG * CH, 16'd5);
    drain();
    checks++;
    if (n_frame !== 1) begin
      errors++;
      $display("FAIL frame_done_count got=%0d req=1", n_frame);
    end
  endtask

  task automatic test_relu();
    do_reset();
    load_biases(-16'sd20, -16'sd20, -16'sd20);
    stream(IMG, 16'd5);
    drain();
  endtask

  task automatic test_saturation();
    do_reset();
    load_biases(16'h7FFF, 16'h8000, 16'h0000);
    stream(IMG, 16'h0001);
    stream(IMG, 16'hFFFF);
    stream(IMG, 16'h8000);
    drain();
  endtask

  task automatic test_drop();
    do_reset();
    step(0, 16'h0, 1, 16'd5);
    idle();
    checks++;
    if (bus.err_drop !== 1'b1) begin
      errors++;
      $display("FAIL err_drop_load got=%b req=1", bus.err_drop);
    end
    load_biases(16'd7, 16'd7, 16'd7);
    step(0, 16'h0, 1, 16'd1);
    step(0, 16'h0, 1, 16'd2);
    step(1, 16'd3, 1, 16'd9);
    idle();
    checks++;
    if (bus.bias_loaded !== 1'b0 || bus.err_drop !== 1'b1) begin
      errors++;
      $display("FAIL collision got=bl%b/err%b req=bl0/err1", bus.bias_loaded, bus.err_drop);
    end
    step(0, 16'h0, 1, 16'd9);
    idle();
    drain();
    load_biases(16'd3, 16'd7, 16'd7);
    stream(IMG, 16'd9);
    drain();
    checks++;
    if (bus.err_drop !== 1'b1) begin
      errors++;
      $display("FAIL err_drop_sticky got=%b req=1", bus.err_drop);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    load_biases(16'd10, 16'd10, 16'd10);
    step(0, 16'h0, 1, 16'd5);
    step(0, 16'h0, 1, 16'd5);
    step(0, 16'h0, 1, 16'd5);
    do_reset();
    repeat (6) idle();
    load_biases(16'd1, 16'd2, 16'd3);
    stream(IMG * 2, 16'd100);
    drain();
  endtask

  initial begin
    bus.valid_in = 0; bus.valid_bias_in = 0; bus.pxl_in = '0; bus.bias_in = '0;
    test_reset();
    test_frame();
    test_relu();
    test_saturation();
    test_drop();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running req=finished");
    $fatal(1, "timeout");
  end
endmodule
